// File: rtl/game_pkg.sv
// game_pkg: mode codes shared by the game-mode controller and the beep stage,
// plus the controller's state encoding and a counter-width helper.
package game_pkg;

  // Two-bit mode code seen by the beep stage and the rest of the datapath.
  typedef logic [1:0] game_mode_t;

  localparam game_mode_t MODE_IDLE  = 2'b00;
  localparam game_mode_t MODE_START = 2'b01;
  localparam game_mode_t MODE_PLAY  = 2'b10;
  localparam game_mode_t MODE_OVER  = 2'b11;

  // Controller states. The encoding is identical to the mode code, so the
  // registered state can drive gamemode directly with no extra flops.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_PLAY  = 2'b10,
    ST_OVER  = 2'b11
  } game_state_e;

  // Bits needed to hold the values 0 .. n-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/game_mode_ctrl_if.sv
// game_mode_ctrl_if: button/collision inputs and mode outputs of the
// game-mode controller. The game side uses the master modport, the
// controller uses the slave modport.
interface game_mode_ctrl_if;
  import game_pkg::*;

  logic       btn_start;
  logic       hit;
  game_mode_t gamemode;
  logic       mode_changed;
  logic       paused;

  modport master (
    output btn_start,
    output hit,
    input  gamemode,
    input  mode_changed,
    input  paused
  );

  modport slave (
    input  btn_start,
    input  hit,
    output gamemode,
    output mode_changed,
    output paused
  );

endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchronizer, stability counter and rising-edge pulse
// for a raw asynchronous push button. press is a registered one-cycle pulse
// issued the cycle after the debounced level flips 0->1.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic press
);
  import game_pkg::*;

  localparam int unsigned         CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]       CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          level_dly_q, level_dly_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Synchronize, count cycles of disagreement, flip the level after enough of them.
  always_comb begin
    sync1_d     = btn_in;
    sync2_d     = sync1_q;
    level_d     = level_q;
    cnt_d       = '0;
    level_dly_d = level_q;
    press_d     = level_q & ~level_dly_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State register; the synchronous reset clears the whole button path.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      press_q     <= press_d;
      cnt_q       <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/game_mode_ctrl.sv
// game_mode_ctrl: sequences IDLE -> START -> PLAY -> OVER -> IDLE and drives
// the 2-bit gamemode code. START and OVER are fixed-length windows timed by a
// single up-counter that is cleared on every state change.
// Optional feature macro: GAME_PAUSE_EN -- when defined, a press in PLAY
// toggles paused and hit is masked while paused; otherwise paused is 0.
module game_mode_ctrl
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned START_CYCLES    = 200_000_000,
  parameter int unsigned OVER_CYCLES     = 300_000_000
) (
  input logic              clk,
  input logic              rst,
  game_mode_ctrl_if.slave  bus
);

  localparam int unsigned   TMAX       = (START_CYCLES > OVER_CYCLES) ? START_CYCLES : OVER_CYCLES;
  localparam int unsigned   TW         = cnt_width(TMAX);
  localparam logic [TW-1:0] START_LAST = TW'(START_CYCLES - 1);
  localparam logic [TW-1:0] OVER_LAST  = TW'(OVER_CYCLES - 1);

  logic          press;
  game_state_e   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          mode_changed_q, mode_changed_d;
`ifdef GAME_PAUSE_EN
  logic          paused_q, paused_d;
`endif

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk    (clk),
    .rst    (rst),
    .btn_in (bus.btn_start),
    .press  (press)
  );

  // Next state, window timer and change pulse; hit wins over a same-cycle press.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + TW'(1);
`ifdef GAME_PAUSE_EN
    paused_d = paused_q;
`endif
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (press) state_d = ST_START;
      end
      ST_START: begin
        if (timer_q == START_LAST) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        timer_d = '0;
`ifdef GAME_PAUSE_EN
        if (bus.hit && !paused_q) begin
          state_d  = ST_OVER;
          paused_d = 1'b0;
        end else if (press) begin
          paused_d = ~paused_q;
        end
`else
        if (bus.hit) state_d = ST_OVER;
`endif
      end
      ST_OVER: begin
        if (timer_q == OVER_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d != state_q) timer_d = '0;
    mode_changed_d = (state_d != state_q);
  end

  // Mode register; reset returns to IDLE without raising mode_changed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      timer_q        <= '0;
      mode_changed_q <= 1'b0;
`ifdef GAME_PAUSE_EN
      paused_q       <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      mode_changed_q <= mode_changed_d;
`ifdef GAME_PAUSE_EN
      paused_q       <= paused_d;
`endif
    end
  end

  assign bus.gamemode     = game_mode_t'(state_q);
  assign bus.mode_changed = mode_changed_q;
`ifdef GAME_PAUSE_EN
  assign bus.paused       = paused_q;
`else
  assign bus.paused       = 1'b0;
`endif

endmodule

// File: doc/game_mode_ctrl.md
# game_mode_ctrl

- Game-mode controller that produces the 2-bit `gamemode` code consumed by the beep stage and the rest of the game datapath.
- Debounces the raw start button and sequences IDLE → START → PLAY → OVER → IDLE.
- START and OVER are timed windows sized for the start and game-over jingles.
- The beep stage plays its start jingle while `gamemode` = 01 and its game-over jingle while `gamemode` = 11.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: cycles of stable input required to accept a button level change; must be ≥ 1.
- `START_CYCLES`, default 200_000_000: cycles `gamemode` holds 01; must be ≥ 1.
- `OVER_CYCLES`, default 300_000_000: cycles `gamemode` holds 11; must be ≥ 1.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `btn_start`  in  1  raw, asynchronous start/pause button, active-high.
- `hit`  in  1  collision pulse from game logic, synchronous to `clk`.
- `gamemode`  out  2  registered mode code: 00 IDLE, 01 START, 10 PLAY, 11 OVER.
- `mode_changed`  out  1  one-cycle pulse, high in the first cycle `gamemode` shows a new value.
- `paused`  out  1  high while PLAY is paused; tied 0 unless pause is compiled in.

## Operation
- Button path:
  - `btn_start` passes through a 2-FF synchronizer.
  - A debounce counter increments while the synchronized level differs from the debounced level, and clears when they are equal.
  - When the counter reaches `DEBOUNCE_CYCLES`-1 while still differing, the debounced level flips.
  - `press` is a registered 1-cycle pulse issued on a 0→1 flip of the debounced level. A 1→0 flip produces nothing.
- FSM transitions (a single timer is cleared on every state entry):
  - IDLE: `press` → START. `hit` is ignored.
  - START: timer counts; at `START_CYCLES`-1 → PLAY. `press` and `hit` are ignored.
  - PLAY: `hit` → OVER. `press` toggles `paused` when pause is compiled in, otherwise it is ignored.
  - OVER: timer counts; at `OVER_CYCLES`-1 → IDLE. `press` and `hit` are ignored.
- Simultaneous events and pause rules:
  - In PLAY, `hit` and `press` in the same cycle → OVER; the pause toggle is discarded.
  - While `paused` = 1, `hit` is ignored.
  - `paused` clears on leaving PLAY.
- Timer width is sized by `$clog2` of the larger of `START_CYCLES` and `OVER_CYCLES`. The timer never wraps because it is cleared on each state exit.
- Reset values:
  - `gamemode` 00, `mode_changed` 0, `paused` 0.
  - Timer 0, debounce counter 0, synchronizer and debounced level 0.
- Reset mid-operation: at the reset edge, all state returns to the reset values regardless of the current state.
- A button held through reset is registered as a new press `DEBOUNCE_CYCLES` cycles after synchronization.

## Timing
- Button to mode change: a clean `btn_start` rise sampled at edge k gives `gamemode` 00→01 at edge k+`DEBOUNCE_CYCLES`+3.
  - 2 edges for the synchronizer.
  - `DEBOUNCE_CYCLES` edges for the debounce counter.
  - 1 edge for the FSM.
- A glitch shorter than `DEBOUNCE_CYCLES` synchronized cycles causes no change.
- `hit` sampled at edge k in PLAY (not paused) gives `gamemode` = 11 at edge k.
- `gamemode` = 01 is held exactly `START_CYCLES` cycles; `gamemode` = 11 is held exactly `OVER_CYCLES` cycles.
- `mode_changed` is asserted in the same cycle the new `gamemode` first appears, for exactly 1 cycle. It is not asserted on reset.
- `paused` toggles at the edge `press` is sampled.

## Configuration
- Macro `GAME_PAUSE_EN`.
- Defined: `press` in PLAY toggles `paused`; `hit` is masked while paused.
- Undefined: `paused` is constant 0, and `press` in PLAY is ignored.

## Structure
- Shared package `game_pkg` holds:
  - the mode code constants `MODE_IDLE`, `MODE_START`, `MODE_PLAY`, `MODE_OVER`;
  - the 2-bit `game_mode_t` typedef used here and by the beep stage.
- Sub-module `btn_debounce` (parameter `DEBOUNCE_CYCLES`; ports `clk`, `rst`, raw in, `press` out) contains the synchronizer, counter and edge pulse.
- The FSM and timer stay in `game_mode_ctrl`.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `START_CYCLES`=8, `OVER_CYCLES`=6.
- `rst` high 3 cycles with `btn_start`=0 → `gamemode`=00, `mode_changed`=0, `paused`=0 throughout.
- Button timing:
  - `btn_start` high 3 cycles then low → `gamemode` stays 00.
  - `btn_start` high 12 cycles → `gamemode`=01 at edge k+7 with a 1-cycle `mode_changed`, held 8 cycles, then 10.
- In PLAY, `hit` 1 cycle → `gamemode`=11 at that edge, held 6 cycles, then 00. Two `mode_changed` pulses.
- In PLAY, `hit` and `press` in the same cycle → `gamemode`=11 and `paused`=0.
- With `GAME_PAUSE_EN`: press in PLAY → `paused`=1; `hit` ignored (`gamemode` stays 10); press again → `paused`=0. Without the macro, the same stimulus leaves `paused`=0.
- `rst` asserted 1 cycle at cycle 4 of START → `gamemode`=00 at that edge. A new press yields a full 8-cycle START window.
